// File: rtl/cm_config_arbiter_if.sv
// Config-bus arbiter bundle: per-requester write requests plus the shared active-low config bus.
// slave is the arbiter side; master is the requester/sink side.
interface cm_config_arbiter_if #(
    parameter int NUM_REQ      = 3,
    parameter int c_addr_WIDTH = 4,
    parameter int c_data_WIDTH = 16
);
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ*c_addr_WIDTH-1:0] req_addr;
    logic [NUM_REQ*c_data_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]              gnt;
    logic [NUM_REQ-1:0]              done;
    logic [NUM_REQ-1:0]              err;
    logic [c_addr_WIDTH-1:0]         c_addr;
    logic [c_data_WIDTH-1:0]         c_data;
    logic                            c_valid;
    logic                            c_ready;

    modport slave (
        input  req, req_addr, req_data, c_ready,
        output gnt, done, err, c_addr, c_data, c_valid
    );

    modport master (
        output req, req_addr, req_data, c_ready,
        input  gnt, done, err, c_addr, c_data, c_valid
    );
endinterface

// File: rtl/cm_config_arbiter.sv
// Round-robin arbiter for one active-low config bus; grant one cycle after req, done one cycle after ack.
// The bus holds until the sink acks; CM_CFG_TIMEOUT_EN adds an ack timeout that ends the write with err.
module cm_config_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int c_addr_WIDTH   = 4,
    parameter int c_data_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    cm_config_arbiter_if.slave  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("cm_config_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;

    state_t                  state, state_nxt;
    logic [NUM_REQ-1:0]      gnt_q, gnt_nxt;
    logic [NUM_REQ-1:0]      done_q, done_nxt;
    logic                    c_valid_q, c_valid_nxt;
    logic [c_addr_WIDTH-1:0] addr_q, addr_nxt;
    logic [c_data_WIDTH-1:0] data_q, data_nxt;
    logic [IW-1:0]           last_q, last_nxt;
    logic [IW-1:0]           winner;
    logic                    found;
    // Blocks granting on the first edge after reset release.
    logic                    init_q;

`ifdef CM_CFG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]           cnt_q, cnt_nxt;
    logic [NUM_REQ-1:0]      err_q, err_nxt;
`endif

    always_comb begin : p_next
        int idx;
        state_nxt   = state;
        gnt_nxt     = gnt_q;
        done_nxt    = '0;
        c_valid_nxt = c_valid_q;
        addr_nxt    = addr_q;
        data_nxt    = data_q;
        last_nxt    = last_q;
        found       = 1'b0;
        winner      = last_q;
        idx         = 0;
`ifdef CM_CFG_TIMEOUT_EN
        cnt_nxt     = cnt_q;
        err_nxt     = '0;
`endif
        // Search starts just past the last owner and wraps once around.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end

        case (state)
            IDLE: begin
                if (found && init_q) begin
                    state_nxt   = DRIVE;
                    gnt_nxt     = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                    c_valid_nxt = 1'b0;
                    addr_nxt    = bus.req_addr[int'(winner)*c_addr_WIDTH +: c_addr_WIDTH];
                    data_nxt    = bus.req_data[int'(winner)*c_data_WIDTH +: c_data_WIDTH];
                    last_nxt    = winner;
`ifdef CM_CFG_TIMEOUT_EN
                    cnt_nxt     = '0;
`endif
                end
            end
            DRIVE: begin
                if (!bus.c_ready) begin
                    state_nxt   = RELEASE;
                    c_valid_nxt = 1'b1;
                    gnt_nxt     = '0;
                    done_nxt    = gnt_q;
                end
`ifdef CM_CFG_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = RELEASE;
                    c_valid_nxt = 1'b1;
                    gnt_nxt     = '0;
                    err_nxt     = gnt_q;
                end else begin
                    cnt_nxt     = cnt_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (bus.c_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            c_valid_q <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            init_q    <= 1'b0;
`ifdef CM_CFG_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= '0;
`endif
        end else begin
            state     <= state_nxt;
            gnt_q     <= gnt_nxt;
            done_q    <= done_nxt;
            c_valid_q <= c_valid_nxt;
            addr_q    <= addr_nxt;
            data_q    <= data_nxt;
            last_q    <= last_nxt;
            init_q    <= 1'b1;
`ifdef CM_CFG_TIMEOUT_EN
            cnt_q     <= cnt_nxt;
            err_q     <= err_nxt;
`endif
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.c_valid = c_valid_q;
    assign bus.c_addr  = addr_q;
    assign bus.c_data  = data_q;
`ifdef CM_CFG_TIMEOUT_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = '0;
`endif
endmodule

// File: tb/tb_cm_config_arbiter.sv
// Directed bench for cm_config_arbiter: reset, single write, drop, slow release, reset abort, contention, timeout.
module tb_cm_config_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    cm_config_arbiter_if #(.NUM_REQ(3), .c_addr_WIDTH(4), .c_data_WIDTH(16)) bus ();

    cm_config_arbiter #(
        .NUM_REQ(3), .c_addr_WIDTH(4), .c_data_WIDTH(16), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full write with the sink acking one cycle after the grant; ends back in IDLE.
    task automatic xact(input string tag, input logic [2:0] eg, input logic [3:0] ea,
                        input logic [15:0] ed);
        tick();
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(eg));
        chk({tag, "_valid"}, 32'(bus.c_valid), 32'd0);
        chk({tag, "_addr"}, 32'(bus.c_addr), 32'(ea));
        chk({tag, "_data"}, 32'(bus.c_data), 32'(ed));
        tick();
        chk({tag, "_hold"}, 32'({bus.gnt, bus.c_valid, bus.done}), 32'({eg, 1'b0, 3'b000}));
        bus.c_ready = 1'b0;
        tick();
        chk({tag, "_done"}, 32'({bus.done, bus.gnt, bus.c_valid, bus.err}), 32'({eg, 3'b000, 1'b1, 3'b000}));
        bus.c_ready = 1'b1;
        tick();
        chk({tag, "_pulse"}, 32'({bus.done, bus.gnt}), 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.req      = 3'b000;
        bus.req_addr = {4'h3, 4'h2, 4'h1};
        bus.req_data = {16'h0C03, 16'h0B02, 16'h0002};
        bus.c_ready  = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(bus.c_valid), 32'd1);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
        chk("rst_bus", 32'({bus.c_addr, bus.c_data}), 32'd0);

        // Single write from requester 0, req held across reset release
        bus.req = 3'b001;
        tick();
        rst_n = 1'b1;
        tick();
        chk("first_edge_nogrant", 32'({bus.gnt, bus.c_valid}), 32'({3'b000, 1'b1}));
        xact("single", 3'b001, 4'h1, 16'h0002);
        bus.req = 3'b000;

        // Requester 1 drops req mid-write
        bus.req = 3'b010;
        tick();
        chk("drop_gnt", 32'(bus.gnt), 32'b010);
        bus.req = 3'b000;
        tick();
        chk("drop_stable", 32'({bus.gnt, bus.c_valid, bus.c_addr, bus.c_data}),
            32'({3'b010, 1'b0, 4'h2, 16'h0B02}));
        bus.c_ready = 1'b0;
        tick();
        chk("drop_done", 32'({bus.done, bus.c_valid}), 32'({3'b010, 1'b1}));
        bus.c_ready = 1'b1;
        tick();
        chk("drop_idle", 32'({bus.done, bus.gnt}), 32'd0);

        // Slow release: sink keeps c_ready low after the ack
        bus.req = 3'b101;
        tick();
        chk("slow_gnt", 32'(bus.gnt), 32'b100);
        bus.c_ready = 1'b0;
        tick();
        chk("slow_done", 32'(bus.done), 32'b100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("slow_hold", 32'({bus.gnt, bus.c_valid, bus.done, bus.c_addr}),
                32'({3'b000, 1'b1, 3'b000, 4'h3}));
        end
        bus.c_ready = 1'b1;
        tick();
        chk("slow_release_nogrant", 32'(bus.gnt), 32'd0);
        xact("slow_next", 3'b001, 4'h1, 16'h0002);
        bus.req = 3'b000;

        // Reset asserted mid-DRIVE aborts the write
        bus.req = 3'b010;
        tick();
        chk("abort_gnt", 32'(bus.gnt), 32'b010);
        rst_n = 1'b0;
        #1;
        chk("abort_now", 32'({bus.gnt, bus.c_valid, bus.done, bus.err}), 32'({3'b000, 1'b1, 6'b0}));
        bus.c_ready = 1'b0;
        tick();
        chk("abort_no_done", 32'({bus.done, bus.err, bus.c_addr}), 32'd0);
        bus.c_ready = 1'b1;
        bus.req = 3'b111;
        rst_n = 1'b1;
        tick();
        chk("abort_first_edge", 32'(bus.gnt), 32'd0);

        // Contention: round robin restarts at requester 0
        xact("rr0", 3'b001, 4'h1, 16'h0002);
        xact("rr1", 3'b010, 4'h2, 16'h0B02);
        xact("rr2", 3'b100, 4'h3, 16'h0C03);
        xact("rr3", 3'b001, 4'h1, 16'h0002);
        bus.req = 3'b000;

`ifdef CM_CFG_TIMEOUT_EN
        // Sink never acks: err after eight DRIVE cycles
        bus.req = 3'b001;
        tick();
        chk("to_gnt", 32'(bus.gnt), 32'b001);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_wait", 32'({bus.err, bus.done, bus.c_valid}), 32'd0);
        end
        tick();
        chk("to_err", 32'({bus.err, bus.done, bus.c_valid, bus.gnt}), 32'({3'b001, 3'b000, 1'b1, 3'b000}));
        bus.req = 3'b000;
        tick();
        chk("to_pulse", 32'({bus.err, bus.done}), 32'd0);
`else
        bus.req = 3'b001;
        for (int i = 0; i < 12; i++) tick();
        chk("noto_wait", 32'({bus.err, bus.done, bus.gnt, bus.c_valid}), 32'({6'b0, 3'b001, 1'b0}));
        bus.c_ready = 1'b0;
        bus.req = 3'b000;
        tick();
        chk("noto_done", 32'({bus.done, bus.err}), 32'({3'b001, 3'b000}));
        bus.c_ready = 1'b1;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
